hex_display_scheduler: RTL and testbench
========================================

# hex_display_scheduler

Time-multiplexed controller for the six-digit seven-segment bank. It arbitrates digit writes from two requesters with round-robin priority and stores one nibble per digit. A single shared hex decoder is scanned across the six digits, and each decoded pattern is latched into its HEX output register. It sits between producer logic (counters, ALU results) and the HEX0–HEX5 pins.

## Interface
- SCAN_DIV, default 4: clock cycles per scan slot; legal range 1..255.
- Clock  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- req_a  in  1  requester A write request; held until gnt_a.
- idx_a  in  3  requester A target digit, 0..5.
- val_a  in  4  requester A nibble.
- gnt_a  out  1  requester A grant; combinational, same cycle as req_a.
- req_b, idx_b, val_b, gnt_b: same as the A set, for requester B.
- blank  in  6  per-digit blank; bit k set means HEXk shows all segments off.
- HEX0..HEX5  out  7 each  registered segment patterns, active-low, bit i = segment i (a..g).
- scan_idx  out  3  digit index being decoded this slot, 0..5.
- wr_err  out  1  registered one-cycle pulse after a granted write with idx > 5.

## Operation
- Arbiter:
  - At most one grant per cycle.
  - A single active request is granted.
  - If both requests are active, grant the requester not granted most recently. The last-winner pointer resets to "B", so A wins the first tie.
  - The pointer updates only on a grant.
  - gnt_a and gnt_b are 0 while Reset is high.
- Write:
  - On the edge where a grant is high, digit[idx] <= val.
  - If idx > 5, the write is dropped, the grant still completes, and wr_err pulses on the next cycle.
- Digit file: six 4-bit registers, reset to 0.
- Prescaler:
  - pcnt counts 0..SCAN_DIV-1; the slot ends on the edge where pcnt == SCAN_DIV-1.
  - At slot end: HEX[scan_idx] <= blank[scan_idx] ? 7'h7F : decode(digit[scan_idx]); scan_idx <= (scan_idx == 5) ? 0 : scan_idx + 1; pcnt <= 0.
  - At every other edge, HEX[scan_idx] is unchanged.
- Decoder, shared single instance, active-low patterns:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Collisions:
  - A write to digit k on the same edge that latches HEXk latches the old value.
  - The new value appears at the next refresh of k.
  - Blank is sampled only at slot end.
- Reset mid-operation: all state clears asynchronously, including any in-flight grant. Requesters must re-present after Reset falls.

## Timing
- Reset values:
  - HEX0..HEX5 = 7'h7F (blank).
  - scan_idx = 0, pcnt = 0, wr_err = 0, digit[0..5] = 0, last-winner = B.
- After Reset falls:
  - HEX0 gets its first update on edge SCAN_DIV.
  - HEXk gets its first update on edge (k+1)·SCAN_DIV.
  - Full refresh period is 6·SCAN_DIV cycles.
- Grant latency: 0 cycles (combinational). The write commits on the same edge.
- Write-to-display latency: 1 to 6·SCAN_DIV cycles, depending on scan position.
- wr_err: high for exactly one cycle, one edge after the offending grant.
- Sustained throughput: one write per cycle.
- Under continuous contention, grants alternate A, B, A, B.

## Test plan
- Reset then idle, SCAN_DIV=1: HEX0..5 = 7F during reset. After release, HEX0..HEX5 become 40 one per cycle on edges 1..6. scan_idx sequence 0,1,2,3,4,5,0.
- A writes idx=2 val=6 with SCAN_DIV=4: gnt_a=1 in the same cycle. HEX2 becomes 02 on the next slot-end edge where scan_idx==2; other digits stay 40.
- A and B request continuously (A idx0 val=1, B idx1 val=F): grants alternate A, B, A, B starting with A. HEX0 = 79, HEX1 = 0E after one full scan.
- B writes idx=7: gnt_b=1, wr_err pulses for one cycle, no digit changes.
- Write digit 3 = 8 on the same edge HEX3 latches (SCAN_DIV=1): HEX3 keeps its old value. HEX3 = 00 six cycles later. Set blank[3]: HEX3 = 7F at its next refresh.
- Assert Reset mid-scan with req_a held: gnt_a drops immediately, all HEX = 7F, scan_idx = 0. After release, the grant resumes in the first cycle.

Source files
------------

// File: rtl/hex_display_scheduler.sv
// Six-digit seven-segment controller: round-robin write arbiter, digit file,
// and a single shared hex decoder scanned across the HEX output registers.
module hex_display_scheduler #(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       req_a,
    input  logic [2:0] idx_a,
    input  logic [3:0] val_a,
    output logic       gnt_a,
    input  logic       req_b,
    input  logic [2:0] idx_b,
    input  logic [3:0] val_b,
    output logic       gnt_b,
    input  logic [5:0] blank,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [2:0] scan_idx,
    output logic       wr_err
);

    localparam logic [7:0] PCNT_END = 8'(SCAN_DIV - 1);

    logic [3:0] digit [6];
    logic [6:0] hex_r [6];
    logic [7:0] pcnt;
    logic       last_b;
    logic [6:0] seg;

    // last_b set means B won the most recent grant, so A wins the next tie
    assign gnt_a = !rst && req_a && (!req_b || last_b);
    assign gnt_b = !rst && req_b && (!req_a || !last_b);

    always_comb begin
        seg = 7'h7F;
        case (digit[scan_idx])
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) digit[i] <= 4'h0;
            last_b <= 1'b1;
            wr_err <= 1'b0;
        end else begin
            wr_err <= (gnt_a && (idx_a > 3'd5)) || (gnt_b && (idx_b > 3'd5));
            if (gnt_a) begin
                last_b <= 1'b0;
                if (idx_a <= 3'd5) digit[idx_a] <= val_a;
            end else if (gnt_b) begin
                last_b <= 1'b1;
                if (idx_b <= 3'd5) digit[idx_b] <= val_b;
            end
        end
    end

    // The latch reads digit[] before this edge's write lands, so a colliding
    // write shows up only on the following refresh of that digit.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) hex_r[i] <= 7'h7F;
            pcnt     <= 8'd0;
            scan_idx <= 3'd0;
        end else if (pcnt == PCNT_END) begin
            hex_r[scan_idx] <= blank[scan_idx] ? 7'h7F : seg;
            scan_idx        <= (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
            pcnt            <= 8'd0;
        end else begin
            pcnt <= pcnt + 8'd1;
        end
    end

    assign HEX0 = hex_r[0];
    assign HEX1 = hex_r[1];
    assign HEX2 = hex_r[2];
    assign HEX3 = hex_r[3];
    assign HEX4 = hex_r[4];
    assign HEX5 = hex_r[5];

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler; one instance per scan rate
// (SCAN_DIV=1 and SCAN_DIV=4) sharing the same stimulus.
module tb_hex_display_scheduler;

    logic       clk_sys = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [2:0] idx_a = 3'd0, idx_b = 3'd0;
    logic [3:0] val_a = 4'd0, val_b = 4'd0;
    logic [5:0] blank = 6'd0;

    logic       g1a, g1b, g4a, g4b, e1, e4;
    logic [2:0] s1, s4;
    logic [6:0] h1 [6];
    logic [6:0] h4 [6];

    int checks = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    hex_display_scheduler #(.SCAN_DIV(1)) dut1 (
        .clk_sys(clk_sys), .rst(rst),
        .req_a(req_a), .idx_a(idx_a), .val_a(val_a), .gnt_a(g1a),
        .req_b(req_b), .idx_b(idx_b), .val_b(val_b), .gnt_b(g1b),
        .blank(blank),
        .HEX0(h1[0]), .HEX1(h1[1]), .HEX2(h1[2]),
        .HEX3(h1[3]), .HEX4(h1[4]), .HEX5(h1[5]),
        .scan_idx(s1), .wr_err(e1)
    );

    hex_display_scheduler #(.SCAN_DIV(4)) dut4 (
        .clk_sys(clk_sys), .rst(rst),
        .req_a(req_a), .idx_a(idx_a), .val_a(val_a), .gnt_a(g4a),
        .req_b(req_b), .idx_b(idx_b), .val_b(val_b), .gnt_b(g4b),
        .blank(blank),
        .HEX0(h4[0]), .HEX1(h4[1]), .HEX2(h4[2]),
        .HEX3(h4[3]), .HEX4(h4[4]), .HEX5(h4[5]),
        .scan_idx(s4), .wr_err(e4)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic do_reset();
        req_a = 1'b0; req_b = 1'b0; blank = 6'd0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (h1[k] !== 7'h7F || h4[k] !== 7'h7F) begin
                failures++;
                $display("FAIL reset_hex%0d got %h/%h want 7f", k, h1[k], h4[k]);
            end
        end
        checks++;
        if (s1 !== 3'd0 || s4 !== 3'd0 || e1 !== 1'b0 || e4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state scan=%0d/%0d err=%b/%b want 0", s1, s4, e1, e4);
        end
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            checks++;
            if (h1[e-1] !== 7'h40) begin
                failures++;
                $display("FAIL idle_hex%0d edge %0d got %h want 40", e - 1, e, h1[e-1]);
            end
            checks++;
            if (s1 !== 3'(e % 6)) begin
                failures++;
                $display("FAIL idle_scan edge %0d got %0d want %0d", e, s1, e % 6);
            end
            if (e < 6) begin
                checks++;
                if (h1[e] !== 7'h7F) begin
                    failures++;
                    $display("FAIL idle_early_hex%0d edge %0d got %h want 7f", e, e, h1[e]);
                end
            end
        end
    endtask

    task automatic test_write();
        do_reset();
        req_a = 1'b1; idx_a = 3'd2; val_a = 4'd6;
        #1;
        checks++;
        if (g4a !== 1'b1 || g4b !== 1'b0) begin
            failures++;
            $display("FAIL write_gnt got a=%b b=%b want a=1 b=0", g4a, g4b);
        end
        tick(1);
        req_a = 1'b0;
        tick(10);
        checks++;
        if (h4[2] !== 7'h7F) begin
            failures++;
            $display("FAIL write_hex2_early got %h want 7f", h4[2]);
        end
        tick(1);
        checks++;
        if (h4[2] !== 7'h02) begin
            failures++;
            $display("FAIL write_hex2 got %h want 02", h4[2]);
        end
        checks++;
        if (h4[0] !== 7'h40 || h4[1] !== 7'h40 || h4[3] !== 7'h7F) begin
            failures++;
            $display("FAIL write_others got %h %h %h want 40 40 7f", h4[0], h4[1], h4[3]);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_a;
        do_reset();
        req_a = 1'b1; idx_a = 3'd0; val_a = 4'h1;
        req_b = 1'b1; idx_b = 3'd1; val_b = 4'hF;
        exp_a = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (g4a !== exp_a || g4b !== !exp_a) begin
                failures++;
                $display("FAIL rr_cycle%0d got a=%b b=%b want a=%b b=%b", c, g4a, g4b, exp_a, !exp_a);
            end
            tick(1);
            exp_a = !exp_a;
        end
        req_a = 1'b0; req_b = 1'b0;
        tick(20);
        checks++;
        if (h4[0] !== 7'h79 || h4[1] !== 7'h0E) begin
            failures++;
            $display("FAIL rr_display got %h %h want 79 0e", h4[0], h4[1]);
        end
    endtask

    task automatic test_wr_err();
        do_reset();
        req_b = 1'b1; idx_b = 3'd7; val_b = 4'h5;
        #1;
        checks++;
        if (g1b !== 1'b1 || e1 !== 1'b0) begin
            failures++;
            $display("FAIL err_gnt got gnt_b=%b wr_err=%b want 1 0", g1b, e1);
        end
        tick(1);
        req_b = 1'b0;
        checks++;
        if (e1 !== 1'b1 || e4 !== 1'b1) begin
            failures++;
            $display("FAIL err_pulse got %b/%b want 1", e1, e4);
        end
        tick(1);
        checks++;
        if (e1 !== 1'b0) begin
            failures++;
            $display("FAIL err_clear got %b want 0", e1);
        end
        tick(6);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (h1[k] !== 7'h40) begin
                failures++;
                $display("FAIL err_hex%0d got %h want 40", k, h1[k]);
            end
        end
    endtask

    task automatic test_collision();
        do_reset();
        tick(3);
        req_a = 1'b1; idx_a = 3'd3; val_a = 4'h8;
        tick(1);
        req_a = 1'b0;
        checks++;
        if (h1[3] !== 7'h40) begin
            failures++;
            $display("FAIL coll_old got %h want 40", h1[3]);
        end
        tick(6);
        checks++;
        if (h1[3] !== 7'h00) begin
            failures++;
            $display("FAIL coll_new got %h want 00", h1[3]);
        end
        blank = 6'b001000;
        tick(6);
        checks++;
        if (h1[3] !== 7'h7F || h1[2] !== 7'h40) begin
            failures++;
            $display("FAIL blank_hex3 got %h (hex2 %h) want 7f (40)", h1[3], h1[2]);
        end
        blank = 6'd0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(5);
        req_a = 1'b1; idx_a = 3'd0; val_a = 4'h9;
        #1;
        checks++;
        if (g1a !== 1'b1) begin
            failures++;
            $display("FAIL mid_gnt_pre got %b want 1", g1a);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (g1a !== 1'b0 || g4a !== 1'b0) begin
            failures++;
            $display("FAIL mid_gnt_drop got %b/%b want 0", g1a, g4a);
        end
        checks++;
        if (h1[0] !== 7'h7F || h1[4] !== 7'h7F || s1 !== 3'd0 || s4 !== 3'd0) begin
            failures++;
            $display("FAIL mid_clear got hex0=%h hex4=%h scan=%0d/%0d want 7f 7f 0 0",
                     h1[0], h1[4], s1, s4);
        end
        tick(1);
        rst = 1'b0;
        #1;
        checks++;
        if (g1a !== 1'b1) begin
            failures++;
            $display("FAIL mid_gnt_resume got %b want 1", g1a);
        end
        tick(1);
        req_a = 1'b0;
        tick(6);
        checks++;
        if (h1[0] !== 7'h10) begin
            failures++;
            $display("FAIL mid_hex0 got %h want 10", h1[0]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_wr_err();
        test_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
